// File: rtl/frog_hop_controller.sv
`default_nettype none
// ============================================================================
//  Module   : frog_hop_controller
//  Purpose  : Frog movement FSM. One bounded grid hop per key press, a hop
//             animation window and a cooldown, all paced by frame_tick.
//  Revision : 1.0  initial release
// ============================================================================
module frog_hop_controller #(
  parameter int X_WIDTH         = 8,
  parameter int Y_WIDTH         = 8,
  parameter int X_MAX           = 152,
  parameter int Y_MAX           = 112,
  parameter int X_START         = 76,
  parameter int Y_START         = 112,
  parameter int STEP_X          = 8,
  parameter int STEP_Y          = 8,
  parameter int HOP_FRAMES      = 4,
  parameter int COOLDOWN_FRAMES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               respawn,
  input  logic               key_up,
  input  logic               key_down,
  input  logic               key_left,
  input  logic               key_right,
  output logic [X_WIDTH-1:0] frog_x,
  output logic [Y_WIDTH-1:0] frog_y,
  output logic               hopping,
  output logic               hop_done,
  output logic               at_goal
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] HOP      = 2'd1;
  localparam logic [1:0] COOLDOWN = 2'd2;

  // Counter only needs to reach the larger of the two reload values.
  localparam int CNT_MAX = (HOP_FRAMES > COOLDOWN_FRAMES) ? HOP_FRAMES : COOLDOWN_FRAMES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] HOP_LOAD  = CNT_W'(HOP_FRAMES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'((COOLDOWN_FRAMES > 0) ? COOLDOWN_FRAMES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [X_WIDTH-1:0] X_START_V = X_WIDTH'(X_START);
  localparam logic [Y_WIDTH-1:0] Y_START_V = Y_WIDTH'(Y_START);
  localparam logic [X_WIDTH-1:0] STEP_X_N  = X_WIDTH'(STEP_X);
  localparam logic [Y_WIDTH-1:0] STEP_Y_N  = Y_WIDTH'(STEP_Y);

  // Bounds are compared one bit wider so that x+STEP cannot wrap.
  localparam logic [X_WIDTH:0] STEP_X_E = (X_WIDTH+1)'(STEP_X);
  localparam logic [Y_WIDTH:0] STEP_Y_E = (Y_WIDTH+1)'(STEP_Y);
  localparam logic [X_WIDTH:0] X_MAX_E  = (X_WIDTH+1)'(X_MAX);
  localparam logic [Y_WIDTH:0] Y_MAX_E  = (Y_WIDTH+1)'(Y_MAX);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             armed;

  logic             any_key;
  logic [X_WIDTH:0] x_ext, x_plus;
  logic [Y_WIDTH:0] y_ext, y_plus;
  logic             hop_ok;
  logic [X_WIDTH-1:0] tgt_x;
  logic [Y_WIDTH-1:0] tgt_y;

  assign any_key = key_up | key_down | key_left | key_right;
  assign x_ext   = {1'b0, frog_x};
  assign y_ext   = {1'b0, frog_y};
  assign x_plus  = x_ext + STEP_X_E;
  assign y_plus  = y_ext + STEP_Y_E;

  assign hopping = (state == HOP);
  assign at_goal = (frog_y == '0);

  // Select one direction by priority and work out whether that hop stays on the grid.
  always_comb begin
    hop_ok = 1'b0;
    tgt_x  = frog_x;
    tgt_y  = frog_y;
    if (key_up) begin
      hop_ok = (y_ext >= STEP_Y_E);
      tgt_y  = frog_y - STEP_Y_N;
    end else if (key_down) begin
      hop_ok = (y_plus <= Y_MAX_E);
      tgt_y  = y_plus[Y_WIDTH-1:0];
    end else if (key_left) begin
      hop_ok = (x_ext >= STEP_X_E);
      tgt_x  = frog_x - STEP_X_N;
    end else if (key_right) begin
      hop_ok = (x_plus <= X_MAX_E);
      tgt_x  = x_plus[X_WIDTH-1:0];
    end
  end

  // Movement FSM; respawn restores the reset picture and drops any hop in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frog_x   <= X_START_V;
      frog_y   <= Y_START_V;
      state    <= IDLE;
      cnt      <= '0;
      armed    <= 1'b0;
      hop_done <= 1'b0;
    end else if (respawn) begin
      frog_x   <= X_START_V;
      frog_y   <= Y_START_V;
      state    <= IDLE;
      cnt      <= '0;
      armed    <= 1'b0;
      hop_done <= 1'b0;
    end else begin
      hop_done <= 1'b0;
      // A frame with every key released re-arms, so a held key only hops once.
      if (frame_tick && !any_key) begin
        armed <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (frame_tick && armed && any_key) begin
            armed <= 1'b0;
            if (hop_ok) begin
              frog_x <= tgt_x;
              frog_y <= tgt_y;
              state  <= HOP;
              cnt    <= HOP_LOAD;
            end
          end
        end
        HOP: begin
          if (frame_tick) begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_ONE;
            end else begin
              hop_done <= 1'b1;
              cnt      <= COOL_LOAD;
              state    <= (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
            end
          end
        end
        COOLDOWN: begin
          if (frame_tick) begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_ONE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frog_hop_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frog_hop_controller
//  Purpose  : Scoreboard bench for frog_hop_controller against a frame-level
//             reference model of the hop rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_frog_hop_controller;

  localparam int X_MAX   = 152;
  localparam int Y_MAX   = 112;
  localparam int X_START = 76;
  localparam int Y_START = 112;
  localparam int STEP    = 8;
  localparam int HOPS    = 4;
  localparam int COOLS   = 2;

  localparam logic [3:0] K_NONE = 4'b0000;
  localparam logic [3:0] K_UP   = 4'b1000;
  localparam logic [3:0] K_DOWN = 4'b0100;
  localparam logic [3:0] K_LEFT = 4'b0010;
  localparam logic [3:0] K_RGT  = 4'b0001;

  logic       clk = 1'b0;
  logic       rst, frame_tick, respawn;
  logic       key_up, key_down, key_left, key_right;
  logic [7:0] frog_x, frog_y;
  logic       hopping, hop_done, at_goal;

  frog_hop_controller dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .respawn(respawn),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .frog_x(frog_x), .frog_y(frog_y), .hopping(hopping), .hop_done(hop_done),
    .at_goal(at_goal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit hop;
    bit done;
    bit goal;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: position, phase (0 idle, 1 hopping, 2 cooling), frames remaining.
  int m_x, m_y, m_phase, m_left;
  bit m_armed, m_done;

  function automatic void model_reset();
    m_x = X_START; m_y = Y_START; m_phase = 0; m_left = 0;
    m_armed = 0; m_done = 0;
  endfunction

  function automatic void model_edge(bit r, bit rs, bit t, logic [3:0] k);
    int nx, ny;
    if (r || rs) begin
      model_reset();
      return;
    end
    m_done = 0;
    if (m_phase == 0) begin
      if (t && m_armed && k != 0) begin
        nx = m_x; ny = m_y;
        if (k[3])      ny = m_y - STEP;
        else if (k[2]) ny = m_y + STEP;
        else if (k[1]) nx = m_x - STEP;
        else           nx = m_x + STEP;
        m_armed = 0;
        if (nx >= 0 && nx <= X_MAX && ny >= 0 && ny <= Y_MAX) begin
          m_x = nx; m_y = ny; m_phase = 1; m_left = HOPS;
        end
      end
    end else if (t) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        if (m_phase == 1) begin
          m_done = 1;
          m_phase = (COOLS > 0) ? 2 : 0;
          m_left = COOLS;
        end else begin
          m_phase = 0;
        end
      end
    end
    if (t && k == 0) m_armed = 1;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.x = m_x; e.y = m_y; e.hop = (m_phase == 1); e.done = m_done; e.goal = (m_y == 0);
    return e;
  endfunction

  task automatic compare(input string name, input exp_t e);
    checks++;
    if (int'(frog_x) != e.x || int'(frog_y) != e.y || hopping !== e.hop ||
        hop_done !== e.done || at_goal !== e.goal) begin
      errors++;
      $display("FAIL %s @%0t: got x=%0d y=%0d hop=%b done=%b goal=%b, expected x=%0d y=%0d hop=%b done=%b goal=%b",
               name, $time, frog_x, frog_y, hopping, hop_done, at_goal,
               e.x, e.y, e.hop, e.done, e.goal);
    end
  endtask

  // Monitor: the DUT presents fresh outputs after every edge; compare against the oldest prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) compare("edge", exp_q.pop_front());
    end
  end

  // Called at posedge+2: drive inputs for the coming edge and queue what it should produce.
  task automatic step(input bit r, input bit rs, input bit t, input logic [3:0] k);
    rst = r; respawn = rs; frame_tick = t;
    {key_up, key_down, key_left, key_right} = k;
    model_edge(r, rs, t, k);
    exp_q.push_back(model_out());
    @(posedge clk);
    #2;
  endtask

  task automatic frame(input logic [3:0] k, input int gap);
    step(0, 0, 1, k);
    repeat (gap) step(0, 0, 0, k);
  endtask

  // Full press/release cycle: one hop attempt, then enough released frames to finish hop and cooldown.
  task automatic press(input logic [3:0] k);
    frame(k, 1);
    repeat (HOPS + COOLS + 1) frame(K_NONE, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [3:0] k;
    rst = 1; respawn = 0; frame_tick = 0;
    {key_up, key_down, key_left, key_right} = 4'b0;
    model_reset();
    @(posedge clk);
    #2;
    repeat (2) step(1, 0, 0, K_NONE);

    // Held right key: one hop only, full hop window and hop_done pulse.
    frame(K_NONE, 2);
    repeat (6) frame(K_RGT, 2);
    repeat (4) frame(K_NONE, 1);

    // Walk to the right edge, then beyond it (rejected).
    repeat (11) press(K_RGT);

    // Climb to the goal row and one more (rejected).
    repeat (15) press(K_UP);

    // Up and left together: up wins.
    step(0, 1, 0, K_NONE);
    press(K_UP | K_LEFT);
    press(K_DOWN | K_RGT);

    // Respawn mid-hop at x=92.
    step(0, 1, 0, K_NONE);
    press(K_RGT);
    press(K_RGT);
    frame(K_RGT, 1);
    frame(K_RGT, 1);
    step(0, 1, 0, K_RGT);
    repeat (4) frame(K_NONE, 1);

    // Respawn coincident with a tick and a pending press.
    frame(K_NONE, 0);
    step(0, 1, 1, K_LEFT);
    repeat (3) frame(K_LEFT, 1);

    // Asynchronous reset between edges during cooldown, key held through release.
    respawn = 0;
    frame(K_NONE, 1);
    frame(K_RGT, 1);
    repeat (HOPS) frame(K_RGT, 1);
    #1;
    rst = 1;
    model_reset();
    #1;
    compare("async_reset", model_out());
    #1;
    step(1, 0, 0, K_RGT);
    step(1, 0, 1, K_RGT);
    repeat (4) frame(K_RGT, 1);
    repeat (2) frame(K_NONE, 1);

    // Randomised play.
    repeat (700) begin
      k = ($urandom_range(0, 2) == 0) ? K_NONE : 4'($urandom_range(1, 15));
      step(0, ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0), k);
    end

    step(0, 0, 0, K_NONE);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
